// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and types for the MEM pipeline stage
package mem_pkg;

    localparam int BE_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } memState_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte/halfword lane steering, load extraction and alignment check
module lsu_align
    import mem_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [31:0]     storeData,
    input  logic [31:0]     rdata,
    output logic [BE_W-1:0] be,
    output logic [31:0]     wdata,
    output logic [31:0]     loadValue,
    output logic            misalign
);

    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic        signedLoad;

    always_comb begin
        be         = '0;
        wdata      = '0;
        loadValue  = '0;
        misalign   = 1'b0;
        signedLoad = (funct3 == F3_B) || (funct3 == F3_H);
        loadByte   = rdata[{offset, 3'b000} +: 8];
        loadHalf   = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B, F3_BU: begin
                be        = 4'b0001 << offset;
                wdata     = {4{storeData[7:0]}};
                loadValue = {{24{signedLoad & loadByte[7]}}, loadByte};
            end
            F3_H, F3_HU: begin
                be        = offset[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{storeData[15:0]}};
                loadValue = {{16{signedLoad & loadHalf[15]}}, loadHalf};
                misalign  = offset[0];
            end
            default: begin
                be        = 4'b1111;
                wdata     = storeData;
                loadValue = rdata;
                misalign  = |offset;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data-memory handshake, stall/timeout FSM, MEM/WB register
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                ExMem_MemToReg,
    input  logic [31:0]         ExMem_AluResult,
    input  logic                ExMem_MemRead,
    input  logic                ExMem_MemWrite,
    input  logic [31:0]         ExMem_AluB_Pc4,
    input  logic [2:0]          ExMem_Funct3,
    input  logic [4:0]          ExMem_RegRd,
    input  logic                ExMem_RegWrite,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [31:0]         dmem_addr,
    output logic [BE_W-1:0]     dmem_be,
    output logic [31:0]         dmem_wdata,
    input  logic                dmem_ack,
    input  logic [31:0]         dmem_rdata,
    output logic                Mem_Stall,
    output logic                Mem_Misalign,
    output logic                Mem_BusErr,
    output logic [4:0]          MemWb_RegRd,
    output logic                MemWb_RegWrite,
    output logic                MemWb_MemToReg,
    output logic [31:0]         MemWb_AluResult,
    output logic [31:0]         MemWb_ReadData
);

    memState_t       state, stateNext;
    logic [7:0]      waitCnt, waitCntNext;
    logic            aborted, abortedNext;
    logic            acc, isLoad, misalign, reqValid, ackValid;
    logic [BE_W-1:0] alignBe;
    logic [31:0]     alignWdata, loadValue;

    lsu_align uAlign (
        .funct3    (ExMem_Funct3),
        .offset    (ExMem_AluResult[1:0]),
        .storeData (ExMem_AluB_Pc4),
        .rdata     (dmem_rdata),
        .be        (alignBe),
        .wdata     (alignWdata),
        .loadValue (loadValue),
        .misalign  (misalign)
    );

    assign acc    = ExMem_MemRead | ExMem_MemWrite;
    assign isLoad = ExMem_MemRead;

    // After a timeout the aborted instruction is still frozen in EX/MEM for one
    // cycle; 'aborted' keeps it from being reissued while it drains as a bubble.
    assign reqValid = ~rstb & acc & ~misalign & ~aborted;
    assign ackValid = reqValid & dmem_ack;

    always_ff @(posedge clk) begin
        if (rstb) begin
            state   <= IDLE;
            waitCnt <= '0;
            aborted <= 1'b0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            aborted <= abortedNext;
        end
    end

    // waitCnt counts stall cycles already spent, so a WAIT cycle with
    // waitCnt == TIMEOUT-1 is the TIMEOUT-th and final stall cycle.
    always_comb begin
        stateNext    = state;
        waitCntNext  = waitCnt;
        abortedNext  = 1'b0;
        dmem_req     = reqValid;
        dmem_we      = reqValid & ~isLoad;
        dmem_addr    = reqValid ? {ExMem_AluResult[31:2], 2'b00} : '0;
        dmem_be      = reqValid ? alignBe : '0;
        dmem_wdata   = (reqValid & ~isLoad) ? alignWdata : '0;
        Mem_Stall    = reqValid & ~dmem_ack;
        Mem_Misalign = ~rstb & acc & misalign;
        Mem_BusErr   = 1'b0;
        case (state)
            IDLE: begin
                if (reqValid && !dmem_ack) begin
                    stateNext   = WAIT;
                    waitCntNext = 8'd1;
                end
            end
            WAIT: begin
                if (!reqValid || dmem_ack) begin
                    stateNext   = IDLE;
                    waitCntNext = '0;
                end else if (waitCnt == 8'(TIMEOUT - 1)) begin
                    Mem_BusErr  = 1'b1;
                    stateNext   = IDLE;
                    waitCntNext = '0;
                    abortedNext = 1'b1;
                end else begin
                    waitCntNext = waitCnt + 8'd1;
                end
            end
            default: begin
                stateNext   = IDLE;
                waitCntNext = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            MemWb_RegRd     <= '0;
            MemWb_RegWrite  <= 1'b0;
            MemWb_MemToReg  <= 1'b0;
            MemWb_AluResult <= '0;
            MemWb_ReadData  <= '0;
        end else if (Mem_Stall) begin
            MemWb_RegWrite  <= 1'b0;
        end else begin
            MemWb_RegRd     <= ExMem_RegRd;
            MemWb_RegWrite  <= ExMem_RegWrite & ~(acc & misalign) & ~aborted;
            MemWb_MemToReg  <= ExMem_MemToReg;
            MemWb_AluResult <= ExMem_AluResult;
            if (ackValid && isLoad) begin
                MemWb_ReadData <= loadValue;
            end
        end
    end

endmodule
